// File: rtl/mem_access_master.sv
// Initiator for the word-indexed memory port: one load/store request in, one response out.
// Define BYTE_LANE_EN to add reqByteEn and read-merge-write partial stores.
module mem_access_master #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
`ifdef BYTE_LANE_EN
    input  logic [3:0]  reqByteEn,
`endif
    output logic        respValid,
    output logic [31:0] respRData,
    output logic        respError,
    output logic [31:0] Address,
    output logic [31:0] writeData,
    output logic        writeEnable,
    input  logic [31:0] MemData
);

    localparam int CntW = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_WAIT = 3'd2,
        RESP      = 3'd3
`ifdef BYTE_LANE_EN
        , MERGE   = 3'd4
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              reqReady_q, reqReady_d;
    logic              respValid_q, respValid_d;
    logic              respError_q, respError_d;
    logic [31:0]       respRData_q, respRData_d;
    logic [31:0]       address_q, address_d;
    logic [31:0]       writeData_q, writeData_d;
    logic              writeEnable_q, writeEnable_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              badAddr;
    logic              fullStore;

    assign badAddr = (reqAddr[1:0] != 2'b00) || ({2'b00, reqAddr[31:2]} >= 32'(DEPTH));

`ifdef BYTE_LANE_EN
    logic              isWrite_q, isWrite_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        byteEn_q, byteEn_d;
    logic [31:0]       merged;

    assign fullStore = reqWrite && (reqByteEn == 4'hF);

    always_comb begin
        merged = MemData;
        for (int i = 0; i < 4; i++) begin
            if (byteEn_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            isWrite_q <= 1'b0;
            wdata_q   <= 32'h0;
            byteEn_q  <= 4'h0;
        end else begin
            isWrite_q <= isWrite_d;
            wdata_q   <= wdata_d;
            byteEn_q  <= byteEn_d;
        end
    end
`else
    assign fullStore = reqWrite;
`endif

    always_comb begin
        state_d       = state_q;
        reqReady_d    = reqReady_q;
        respValid_d   = 1'b0;
        respError_d   = respError_q;
        respRData_d   = respRData_q;
        address_d     = address_q;
        writeData_d   = writeData_q;
        writeEnable_d = 1'b0;
        cnt_d         = cnt_q;
`ifdef BYTE_LANE_EN
        isWrite_d     = isWrite_q;
        wdata_d       = wdata_q;
        byteEn_d      = byteEn_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (reqValid && reqReady_q) begin
                    reqReady_d = 1'b0;
`ifdef BYTE_LANE_EN
                    isWrite_d  = reqWrite;
                    wdata_d    = reqWData;
                    byteEn_d   = reqByteEn;
`endif
                    if (badAddr) begin
                        state_d     = RESP;
                        respValid_d = 1'b1;
                        respError_d = 1'b1;
`ifdef BYTE_LANE_EN
                    end else if (reqWrite && (reqByteEn == 4'h0)) begin
                        state_d     = RESP;
                        respValid_d = 1'b1;
                        respError_d = 1'b0;
`endif
                    end else begin
                        address_d   = {2'b00, reqAddr[31:2]};
                        respError_d = 1'b0;
                        if (fullStore) begin
                            state_d       = WRITE;
                            writeEnable_d = 1'b1;
                            writeData_d   = reqWData;
                        end else begin
                            state_d = READ_WAIT;
                            cnt_d   = CntW'(WAIT_CYCLES);
                        end
                    end
                end
            end
            WRITE: begin
                state_d     = RESP;
                respValid_d = 1'b1;
                respError_d = 1'b0;
            end
            READ_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
`ifdef BYTE_LANE_EN
                end else if (isWrite_q) begin
                    // The merged word is registered straight into the write cycle, so MERGE is the write.
                    state_d       = MERGE;
                    writeData_d   = merged;
                    writeEnable_d = 1'b1;
`endif
                end else begin
                    state_d     = RESP;
                    respValid_d = 1'b1;
                    respRData_d = MemData;
                end
            end
`ifdef BYTE_LANE_EN
            MERGE: begin
                state_d     = RESP;
                respValid_d = 1'b1;
                respError_d = 1'b0;
            end
`endif
            RESP: begin
                state_d    = IDLE;
                reqReady_d = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                reqReady_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            reqReady_q    <= 1'b1;
            respValid_q   <= 1'b0;
            respError_q   <= 1'b0;
            respRData_q   <= 32'h0;
            address_q     <= 32'h0;
            writeData_q   <= 32'h0;
            writeEnable_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            reqReady_q    <= reqReady_d;
            respValid_q   <= respValid_d;
            respError_q   <= respError_d;
            respRData_q   <= respRData_d;
            address_q     <= address_d;
            writeData_q   <= writeData_d;
            writeEnable_q <= writeEnable_d;
            cnt_q         <= cnt_d;
        end
    end

    assign reqReady    = reqReady_q;
    assign respValid   = respValid_q;
    assign respError   = respError_q;
    assign respRData   = respRData_q;
    assign Address     = address_q;
    assign writeData   = writeData_q;
    assign writeEnable = writeEnable_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: two instances (WAIT_CYCLES 0 and 3) share one request stream
// and are checked against a word-array reference model; BYTE_LANE_EN adds partial-store cases.
`timescale 1ns/1ps
module tb_mem_access_master;

    localparam int Depth = 1024;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        clearMem;
    logic        reqValid;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
`ifdef BYTE_LANE_EN
    logic [3:0]  reqByteEn;
`endif

    logic        reqReady0, respValid0, respError0, writeEnable0;
    logic [31:0] respRData0, address0, writeData0, memData0;
    logic        reqReady3, respValid3, respError3, writeEnable3;
    logic [31:0] respRData3, address3, writeData3, memData3;

    logic [31:0] mem0   [0:Depth-1];
    logic [31:0] mem3   [0:Depth-1];
    logic [31:0] refMem [0:Depth-1];
    logic [31:0] lastRd;

    int checkCount = 0;
    int passCount  = 0;

    always #5 Clk = ~Clk;

    mem_access_master #(.DEPTH(Depth), .WAIT_CYCLES(0)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .reqValid(reqValid), .reqReady(reqReady0),
        .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWData(reqWData),
`ifdef BYTE_LANE_EN
        .reqByteEn(reqByteEn),
`endif
        .respValid(respValid0), .respRData(respRData0), .respError(respError0),
        .Address(address0), .writeData(writeData0), .writeEnable(writeEnable0),
        .MemData(memData0)
    );

    mem_access_master #(.DEPTH(Depth), .WAIT_CYCLES(3)) u3 (
        .Clk(Clk), .Reset_n(Reset_n), .reqValid(reqValid), .reqReady(reqReady3),
        .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWData(reqWData),
`ifdef BYTE_LANE_EN
        .reqByteEn(reqByteEn),
`endif
        .respValid(respValid3), .respRData(respRData3), .respError(respError3),
        .Address(address3), .writeData(writeData3), .writeEnable(writeEnable3),
        .MemData(memData3)
    );

    // Memories read combinationally and capture on the rising edge.
    always_comb memData0 = (address0 < 32'(Depth)) ? mem0[address0[9:0]] : 32'hBAD0BAD0;
    always_comb memData3 = (address3 < 32'(Depth)) ? mem3[address3[9:0]] : 32'hBAD0BAD0;

    always @(posedge Clk) begin
        if (clearMem) begin
            for (int i = 0; i < Depth; i++) begin
                mem0[i] <= 32'h0;
                mem3[i] <= 32'h0;
            end
        end else begin
            if (writeEnable0) mem0[address0[9:0]] <= writeData0;
            if (writeEnable3) mem3[address3[9:0]] <= writeData3;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    function automatic int expLat(input logic wr, input logic err, input logic [3:0] be, input int w);
        if (err) return 1;
        if (wr) begin
            if (be == 4'h0) return 1;
            if (be != 4'hF) return 3 + w;
            return 2;
        end
        return 2 + w;
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW, input logic [3:0] be);
        logic [31:0] r;
        r = oldW;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = newW[8*i +: 8];
        return r;
    endfunction

    task automatic waitReady();
        int n;
        n = 0;
        while (!(reqReady0 && reqReady3) && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!(reqReady0 && reqReady3)) checkOutput("readyTimeout", {31'd0, reqReady0 & reqReady3}, 32'd1);
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic expErr, input logic [31:0] expRd,
                                 input string name);
        int lat0, lat3, wen0, wen3, rv0, rv3, want0, want3;
        logic [31:0] idx, expWData, rdWant;
        logic stored;
        idx      = {2'b00, addr[31:2]};
        want0    = expLat(wr, expErr, be, 0);
        want3    = expLat(wr, expErr, be, 3);
        stored   = wr && !expErr && (be != 4'h0);
        expWData = stored ? mergeWord(refMem[idx[9:0]], wdata, be) : 32'h0;
        rdWant   = (!wr && !expErr) ? expRd : lastRd;
        @(negedge Clk);
        waitReady();
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        reqWData = wdata;
`ifdef BYTE_LANE_EN
        reqByteEn = be;
`endif
        @(negedge Clk);
        reqValid = 1'b0;
        lat0 = 0; lat3 = 0; wen0 = 0; wen3 = 0; rv0 = 0; rv3 = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge Clk);
            if (writeEnable0) begin
                wen0++;
                checkOutput({name, ":addr0"}, address0, idx);
                checkOutput({name, ":wdata0"}, writeData0, expWData);
            end
            if (writeEnable3) begin
                wen3++;
                checkOutput({name, ":addr3"}, address3, idx);
                checkOutput({name, ":wdata3"}, writeData3, expWData);
            end
            if (respValid0) begin
                rv0++;
                if (lat0 == 0) begin
                    lat0 = k;
                    checkOutput({name, ":err0"}, {31'd0, respError0}, {31'd0, expErr});
                    checkOutput({name, ":rdata0"}, respRData0, rdWant);
                end
            end
            if (respValid3) begin
                rv3++;
                if (lat3 == 0) begin
                    lat3 = k;
                    checkOutput({name, ":err3"}, {31'd0, respError3}, {31'd0, expErr});
                    checkOutput({name, ":rdata3"}, respRData3, rdWant);
                end
            end
            if (lat0 != 0 && k == lat0 + 1) checkOutput({name, ":ready0"}, {31'd0, reqReady0}, 32'd1);
            if (lat3 != 0 && k == lat3 + 1) checkOutput({name, ":ready3"}, {31'd0, reqReady3}, 32'd1);
        end
        checkOutput({name, ":lat0"}, lat0, want0);
        checkOutput({name, ":lat3"}, lat3, want3);
        checkOutput({name, ":respCount0"}, rv0, 1);
        checkOutput({name, ":respCount3"}, rv3, 1);
        checkOutput({name, ":wenCount0"}, wen0, stored ? 1 : 0);
        checkOutput({name, ":wenCount3"}, wen3, stored ? 1 : 0);
        if (stored) begin
            refMem[idx[9:0]] = expWData;
            checkOutput({name, ":mem0"}, mem0[idx[9:0]], expWData);
            checkOutput({name, ":mem3"}, mem3[idx[9:0]], expWData);
        end
        lastRd = rdWant;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expErr;
        logic [31:0] expRData;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int early3, readyEarly3, rvSeen;
        Reset_n  = 1'b0;
        clearMem = 1'b1;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr  = 32'h0;
        reqWData = 32'h0;
`ifdef BYTE_LANE_EN
        reqByteEn = 4'hF;
`endif
        lastRd = 32'h0;
        for (int i = 0; i < Depth; i++) refMem[i] = 32'h0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h0000_0012, 32'h0BAD0BAD, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_1000, 32'h0BAD0BAD, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,        1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0008, 32'h0000_0002, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0FFC, 32'h12345678, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,        1'b0, 32'h12345678};
        vecs[9]  = '{1'b0, 32'h0000_0003, 32'h0,        1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,        1'b0, 32'h0000_0002};

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("reset:ready0", {31'd0, reqReady0}, 32'd1);
        checkOutput("reset:ready3", {31'd0, reqReady3}, 32'd1);
        checkOutput("reset:valid0", {31'd0, respValid0}, 32'd0);
        checkOutput("reset:err0", {31'd0, respError0}, 32'd0);
        checkOutput("reset:rdata0", respRData0, 32'h0);
        checkOutput("reset:addr0", address0, 32'h0);
        checkOutput("reset:wdata0", writeData0, 32'h0);
        checkOutput("reset:wen0", {31'd0, writeEnable0}, 32'd0);
        checkOutput("reset:wen3", {31'd0, writeEnable3}, 32'd0);
        clearMem = 1'b0;
        Reset_n  = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, vecs[i].expErr,
                          vecs[i].expRData, $sformatf("vec%0d", i));
        end

        // A request held high while busy must wait for reqReady on the slow instance.
        @(negedge Clk);
        waitReady();
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = 32'h8;
        reqWData = 32'h0;
        @(negedge Clk);
        reqWrite = 1'b1;
        reqAddr  = 32'h30;
        reqWData = 32'hCAFEF00D;
        early3 = 0;
        readyEarly3 = 0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge Clk);
            if (k == 2) begin
                checkOutput("busy:valid0", {31'd0, respValid0}, 32'd1);
                checkOutput("busy:rdata0", respRData0, 32'h2);
            end
            if (k == 5) begin
                checkOutput("busy:valid3", {31'd0, respValid3}, 32'd1);
                checkOutput("busy:rdata3", respRData3, 32'h2);
            end
            if (k <= 6 && writeEnable3) early3++;
            if (k <= 5 && reqReady3) readyEarly3++;
            if (k == 7) begin
                checkOutput("busy:wen3", {31'd0, writeEnable3}, 32'd1);
                checkOutput("busy:addr3", address3, 32'hC);
                checkOutput("busy:wdata3", writeData3, 32'hCAFEF00D);
                reqValid = 1'b0;
            end
        end
        checkOutput("busy:earlyWrite3", early3, 0);
        checkOutput("busy:earlyReady3", readyEarly3, 0);
        refMem[12] = 32'hCAFEF00D;
        lastRd = 32'h2;
        repeat (8) @(negedge Clk);
        checkOutput("busy:mem0", mem0[12], refMem[12]);
        checkOutput("busy:mem3", mem3[12], refMem[12]);

        // Reset while the store sits in its write cycle must abort it before the capture edge.
        waitReady();
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 32'h20;
        reqWData = 32'h55;
        @(negedge Clk);
        reqValid = 1'b0;
        checkOutput("rst:wenBefore0", {31'd0, writeEnable0}, 32'd1);
        checkOutput("rst:wenBefore3", {31'd0, writeEnable3}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        checkOutput("rst:wen0", {31'd0, writeEnable0}, 32'd0);
        checkOutput("rst:wen3", {31'd0, writeEnable3}, 32'd0);
        checkOutput("rst:ready0", {31'd0, reqReady0}, 32'd1);
        checkOutput("rst:valid0", {31'd0, respValid0}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        lastRd = 32'h0;
        rvSeen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (respValid0 || respValid3) rvSeen++;
        end
        checkOutput("rst:noResp", rvSeen, 0);
        checkOutput("rst:mem0", mem0[8], refMem[8]);
        checkOutput("rst:mem3", mem3[8], refMem[8]);
        checkOutput("rst:readyAfter3", {31'd0, reqReady3}, 32'd1);
        checkOutput("rst:rdata0", respRData0, lastRd);

`ifdef BYTE_LANE_EN
        applyStimulus(1'b1, 32'h4, 32'h11223344, 4'hF, 1'b0, 32'h0, "bl:full");
        applyStimulus(1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, "bl:partial");
        checkOutput("bl:word1", mem0[1], 32'h11BB33DD);
        applyStimulus(1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, "bl:noLanes");
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h3, 1'b0, 32'h11BB33DD, "bl:load");
`endif

        for (int i = 0; i < 40; i++) begin
            logic        wr;
            logic        err;
            logic [31:0] addr, wdata, idx;
            logic [3:0]  be;
            int          sel;
            wr  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      addr = ($urandom_range(0, 15) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 1) addr = 32'h1000 + ($urandom_range(0, 255) << 2);
            else if (sel == 2) addr = 32'hFFC - ($urandom_range(0, 3) << 2);
            else               addr = $urandom_range(0, 15) << 2;
            wdata = $urandom;
            be    = 4'hF;
`ifdef BYTE_LANE_EN
            if ($urandom_range(0, 2) == 0) be = 4'($urandom);
`endif
            idx = {2'b00, addr[31:2]};
            err = (addr[1:0] != 2'b00) || (idx >= 32'(Depth));
            applyStimulus(wr, addr, wdata, be, err,
                          (!wr && !err) ? refMem[idx[9:0]] : 32'h0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
